// File: rtl/quark_fetch_align.sv
`default_nettype none
// =============================================================================
// quark_fetch_align: nibble FIFO that decodes and issues one variable-length
// quark instruction (opcode + 0/2/4/8 immediate nibbles) per cycle.
// Revision: 1.0
// =============================================================================
module quark_fetch_align #(
   parameter int WORD_W      = 32,
   parameter int DEPTH_WORDS = 2,
   parameter int PC_W        = 16,
   parameter bit SIGN_EXT    = 1'b0
) (
   input  logic                                            clk,
   input  logic                                            reset_n,
   input  logic                                            in_valid,
   input  logic [WORD_W-1:0]                               in_data,
   output logic                                            in_ready,
   input  logic                                            flush,
   input  logic [PC_W-1:0]                                 flush_pc,
   output logic                                            out_valid,
   input  logic                                            out_ready,
   output logic [3:0]                                      out_op,
   output logic [31:0]                                     out_imm,
   output logic [3:0]                                      out_len,
   output logic [PC_W-1:0]                                 out_pc,
   output logic [$clog2(DEPTH_WORDS*(WORD_W/4)+1)-1:0]     level
);

   localparam int c_NPW   = WORD_W / 4;
   localparam int c_CAP   = DEPTH_WORDS * c_NPW;
   localparam int c_PTR_W = $clog2(c_CAP);
   localparam int c_LVL_W = $clog2(c_CAP + 1);

   generate
      if ((c_CAP < 8 + c_NPW) || (WORD_W % 4 != 0)) begin : g_param_check
         $error("quark_fetch_align: WORD_W must be a multiple of 4 and CAP >= 8+NPW");
      end
   endgenerate

   logic [3:0]         mem_q [c_CAP];
   logic [c_PTR_W-1:0] head_q, head_d;
   logic [c_LVL_W-1:0] level_q, level_d;
   logic [PC_W-1:0]    pc_q, pc_d;

   logic [3:0]         w_op;
   logic [3:0]         w_imm_len;
   logic [3:0]         w_len;
   logic [31:0]        w_imm_raw;
   logic [31:0]        w_imm;
   logic               w_out_valid;
   logic               w_in_ready;
   logic               w_push;
   logic               w_pop;
   logic [c_PTR_W-1:0] w_tail;

   // Operands never exceed 2*CAP-1, so a single conditional subtract wraps them.
   function automatic logic [c_PTR_W-1:0] f_wrap(input int idx);
      if (idx >= c_CAP) begin
         return c_PTR_W'(idx - c_CAP);
      end
      return c_PTR_W'(idx);
   endfunction

   assign w_op = mem_q[head_q];

   always_comb begin
      case (w_op)
         4'b0001: w_imm_len = 4'd2;
         4'b0010: w_imm_len = 4'd4;
         4'b0011: w_imm_len = 4'd8;
         default: w_imm_len = 4'd0;
      endcase
   end

   assign w_len = w_imm_len + 4'd1;

   always_comb begin
      w_imm_raw = '0;
      for (int k = 0; k < 8; k++) begin
         if (k < int'(w_imm_len)) begin
            w_imm_raw[4*k +: 4] = mem_q[f_wrap(int'(head_q) + 1 + k)];
         end
      end
   end

   always_comb begin
      w_imm = w_imm_raw;
      if (SIGN_EXT) begin
         case (w_imm_len)
            4'd2:    w_imm = {{24{w_imm_raw[7]}},  w_imm_raw[7:0]};
            4'd4:    w_imm = {{16{w_imm_raw[15]}}, w_imm_raw[15:0]};
            default: w_imm = w_imm_raw;
         endcase
      end
   end

   // Readiness looks at the current level only; a same-cycle pop earns no credit.
   assign w_out_valid = (level_q >= c_LVL_W'(w_len));
   assign w_in_ready  = (level_q <= c_LVL_W'(c_CAP - c_NPW)) && !flush;
   assign w_push      = in_valid && w_in_ready;
   assign w_pop       = w_out_valid && out_ready && !flush;
   assign w_tail      = f_wrap(int'(head_q) + int'(level_q));

   always_comb begin
      head_d  = head_q;
      level_d = level_q;
      pc_d    = pc_q;
      if (flush) begin
         head_d  = '0;
         level_d = '0;
         pc_d    = flush_pc;
      end else begin
         if (w_pop) begin
            head_d = f_wrap(int'(head_q) + int'(w_len));
            pc_d   = pc_q + PC_W'(w_len);
         end
         level_d = level_q
                 + (w_push ? c_LVL_W'(c_NPW) : c_LVL_W'(0))
                 - (w_pop  ? c_LVL_W'(w_len) : c_LVL_W'(0));
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         for (int i = 0; i < c_NPW; i++) begin
            mem_q[f_wrap(int'(w_tail) + i)] <= in_data[4*i +: 4];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         level_q <= '0;
         pc_q    <= '0;
      end else begin
         head_q  <= head_d;
         level_q <= level_d;
         pc_q    <= pc_d;
      end
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_op    = w_op;
   assign out_imm   = w_imm;
   assign out_len   = w_len;
   assign out_pc    = pc_q;
   assign level     = level_q;

endmodule
`default_nettype wire

// File: doc/quark_fetch_align.md
Name: quark_fetch_align

Overview:
- Parametrised nibble-granular instruction fetch/align queue for the quark stack core.
- Accepts fetch words over a valid/ready handshake and buffers them as a nibble FIFO.
- Decodes the variable-length instruction at the head (opcode nibble plus 0/2/4/8 immediate nibbles) and issues one aligned instruction per cycle with its immediate and nibble PC.
- Supports flush/redirect and selectable sign or zero extension of immediates.

Parameters:
WORD_W, 32, fetch word width in bits; multiple of 4; NPW = WORD_W/4 nibbles per word.
DEPTH_WORDS, 2, buffer capacity in words; CAP = DEPTH_WORDS*NPW nibbles; must satisfy CAP >= 8+NPW (elaboration error otherwise).
PC_W, 16, width of the nibble program counter.
SIGN_EXT, 0, 1 = sign-extend immediate from its top nibble to 32 bits; 0 = zero-extend.

Ports:
clk  input  1  clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  fetch word valid.
in_data  input  WORD_W  fetch word; nibble 0 = bits [3:0] is consumed first.
in_ready  output  1  buffer can accept a word this cycle.
flush  input  1  discard buffer contents and redirect PC.
flush_pc  input  PC_W  new nibble PC, loaded on flush.
out_valid  output  1  complete instruction present at head.
out_ready  input  1  consumer takes instruction.
out_op  output  4  opcode nibble.
out_imm  output  32  immediate, extended per SIGN_EXT; 0 when no immediate.
out_len  output  4  total instruction length in nibbles, 1..9.
out_pc  output  PC_W  nibble address of the opcode.
level  output  clog2(CAP+1)  nibbles currently buffered.

Behaviour:
- Reset (async, reset_n=0): level=0, head pointer=0, pc=0. Outputs: out_valid=0, in_ready=1, out_pc=0, out_op/out_imm/out_len driven from empty buffer (don't-care while out_valid=0). Storage contents need no reset.
- Immediate length from opcode:
  - 4'b0001 -> 2 nibbles.
  - 4'b0010 -> 4 nibbles.
  - 4'b0011 -> 8 nibbles.
  - All other opcodes -> 0 nibbles.
  - out_len = 1 + immediate length.
- Immediate nibbles are little-endian: the first nibble after the opcode is imm[3:0].
  - SIGN_EXT=1: bit (4*n-1) is replicated up to bit 31.
  - 8-nibble immediates are never extended.
- out_valid = (level >= out_len), computed from head decode.
- in_ready = (CAP - level >= NPW) && !flush. It is based on the current level only, with no credit for a same-cycle pop.
- Outputs are functions of registered state plus flush only; in_data never reaches outputs combinationally. Minimum push-to-issue latency is 1 cycle.
- Push (in_valid && in_ready): append NPW nibbles at the tail.
- Pop (out_valid && out_ready && !flush): head advances by out_len; pc <= pc + out_len, modulo 2^PC_W.
- Simultaneous push and pop: level <= level + NPW - out_len.
- Pointers wrap modulo CAP. An instruction may straddle the word boundary and the physical buffer wrap.
- Flush has priority: level<=0, head<=0, pc<=flush_pc. Any concurrent input word is dropped (in_ready=0) and any concurrent pop is ignored. out_valid=0 from the next cycle until new words arrive.
- With out_valid=1 and out_ready=0, all out_* hold stable.
- Reset asserted mid-operation clears state immediately, regardless of clock.
- Full (level > CAP-NPW): in_ready=0. The CAP constraint guarantees a 9-nibble instruction always fits, so there is no deadlock.

Test Plan:
- Sequence decode: WORD_W=32. Push 0x87654321, out_ready=1. Required issues in order:
  - op1 imm=0x32 len=3 pc=0.
  - Then op4, op5, op6, op7, op8, each imm=0 len=1, pc=3..7.
  - out_valid=0 afterwards.
- Straddling 8-nibble immediate: push 0x76543213 then 0x00000008.
  - Required first issue: op3 imm=0x87654321 len=9 pc=0. It must not be valid after the first word alone.
  - Then seven op0, len=1, pc=9..15.
- Sign extension: push 0x000008F1.
  - SIGN_EXT=1: op1 imm=0xFFFFFF8F.
  - SIGN_EXT=0: op1 imm=0x0000008F.
- Backpressure: out_ready=0, offer 3 words. Required: two accepted, level=16, in_ready=0, third word held, out_* stable. Then out_ready=1 drains in order and the third word is accepted once level<=8.
- Flush: with level=10, in_valid=1, out_ready=1, pulse flush with flush_pc=0x0010. Required next cycle: level=0, out_valid=0, input word not accepted. The next pushed instruction issues with pc=0x0010.
- PC wrap and reset: PC_W=4, flush_pc=0xE, push 0x00000000. Required pc sequence E, F, 0, 1, ... Asserting reset_n=0 mid-stream forces level=0, out_valid=0, pc=0 without a clock edge.
